game_flow_controller: RTL and testbench
=======================================

GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 Parameter NUM_LEVELS, default 6, number of levels; legal range 1-16.
REQ-002 Parameter INIT_FRAMES, default 2, number of frames initialize_level is held per level load; legal range 1-255.
REQ-003 Parameter DEATH_FRAMES, default 30, length in frames of the death sequence and of the level-complete sequence; legal range 1-255.
REQ-004 CLK  input  1  50 MHz system clock; all logic is in this single clock domain.
REQ-005 RESET  input  1  reset; synchronous, active-high.
REQ-006 vs  input  1  VGA vertical sync, active-low, generated from CLK.
REQ-007 start  input  1  start/restart button, active-high level.
REQ-008 dead  input  1  player/obstacle collision, level.
REQ-009 new_level  input  1  player is on the goal tile with all coins collected, level.
REQ-010 initialize_level  output  1  high while the current level's map, obstacles, coins and player start are being loaded.
REQ-011 level_idx  output  4  current level number, 0-based.
REQ-012 deaths_bcd  output  16  death count as 4 BCD digits (for the HEX display).
REQ-013 freeze  output  1  inhibits player movement and obstacle motion.
REQ-014 fade  output  4  screen dim level, 0 = normal, 15 = darkest.
REQ-015 game_won  output  1  high after the last level is cleared.

Function
REQ-016 A frame tick SHALL be a single CLK-cycle pulse on each rising edge of vs, detected from a registered copy vs_q (tick = !vs_q && vs).
REQ-017 The block SHALL implement an FSM with states IDLE, LOAD, PLAY, DYING, LVL_DONE and WON; all outputs SHALL be registered and SHALL change one CLK after the causing event.
REQ-018 A start press SHALL be a rising edge of start, detected by a registered copy of start.
REQ-019 IDLE: on a start press -> LOAD, with level_idx=0 and deaths_bcd=0.
REQ-020 LOAD: initialize_level=1 and freeze=1; fade SHALL be 0 at LOAD entry; after INIT_FRAMES frame ticks -> PLAY with initialize_level=0 in the same cycle.
REQ-021 PLAY: freeze=0 and fade=0; new_level=1 -> LVL_DONE; otherwise dead=1 -> DYING.
REQ-022 If dead and new_level are both high in the same cycle in PLAY, new_level SHALL win.
REQ-023 DYING: on entry, deaths_bcd SHALL be incremented once as a BCD value (digit 9 carries to the next digit) and SHALL saturate at 9999.
REQ-024 DYING: fade SHALL increment on each frame tick, saturating at 15; after DEATH_FRAMES ticks -> LOAD with the same level_idx.
REQ-025 LVL_DONE: fade SHALL behave as in DYING; after DEATH_FRAMES ticks, if level_idx==NUM_LEVELS-1 -> WON, else level_idx+1 -> LOAD.
REQ-026 WON: game_won=1, freeze=1, fade held; on a start press -> LOAD with level_idx=0, deaths_bcd=0, game_won=0.
REQ-027 dead and new_level SHALL be ignored in every state except PLAY; a start press SHALL be ignored in LOAD, PLAY, DYING and LVL_DONE.
REQ-028 The frame counter SHALL be 8 bits and SHALL clear on every state transition.
REQ-029 freeze SHALL be 1 in every state except PLAY.

Reset
REQ-030 RESET=1 at a CLK edge SHALL, at any time including mid-LOAD or mid-DYING, force state=IDLE, level_idx=0, deaths_bcd=0, initialize_level=0, freeze=1, fade=0, game_won=0, frame counter=0, vs_q=1 and start edge register=1.
REQ-031 Forcing vs_q=1 and the start edge register=1 on reset SHALL prevent a spurious frame tick or start press in the first cycle after reset.

Verification
REQ-032 Reset, start held high through deassertion, then released and pressed again -> no LOAD until the second rising edge; then initialize_level=1 for exactly 2 frame ticks, then PLAY with freeze=0.
REQ-033 In PLAY, 1-cycle dead pulse -> deaths_bcd 0x0000->0x0001 next cycle; fade reaches 15 by tick 15; LOAD at tick 30 with level_idx unchanged; further dead pulses during DYING leave the count at 0x0001.
REQ-034 deaths_bcd preloaded to 0x0009 / 0x0099 / 0x9999 and a death applied -> 0x0010 / 0x0100 / 0x9999.
REQ-035 dead and new_level both asserted in the same cycle in PLAY -> LVL_DONE, deaths unchanged; after 30 ticks level_idx 0->1 and initialize_level=1.
REQ-036 Clear all 6 levels -> WON with game_won=1 and level_idx=5; start press -> level_idx=0, deaths_bcd=0, LOAD.
REQ-037 RESET asserted for 1 cycle in mid-DYING with fade=7 -> next cycle IDLE, fade=0, freeze=1, deaths_bcd=0.

Source files
------------

// File: rtl/game_flow_controller_if.sv
// Player/frame inputs and status outputs of the game flow controller.
// master drives the inputs (game logic / bench); slave is the controller itself.
interface game_flow_controller_if;
    logic        vs;
    logic        start;
    logic        dead;
    logic        new_level;
    logic        initialize_level;
    logic [3:0]  level_idx;
    logic [15:0] deaths_bcd;
    logic        freeze;
    logic [3:0]  fade;
    logic        game_won;

    modport master (
        output vs, start, dead, new_level,
        input  initialize_level, level_idx, deaths_bcd, freeze, fade, game_won
    );

    modport slave (
        input  vs, start, dead, new_level,
        output initialize_level, level_idx, deaths_bcd, freeze, fade, game_won
    );
endinterface

// File: rtl/game_flow_controller.sv
// Level / death / win sequencing for a tile game, paced by VGA frame ticks.
// Every output is a register loaded from the next-state decision, so it moves one CLK after its cause.
module game_flow_controller #(
    parameter int unsigned NUM_LEVELS   = 6,
    parameter int unsigned INIT_FRAMES  = 2,
    parameter int unsigned DEATH_FRAMES = 30
) (
    input  logic                 CLK,
    input  logic                 RESET,
    game_flow_controller_if.slave bus
);
    localparam int unsigned LVL_W  = 4;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned BCD_W  = 16;
    localparam int unsigned FADE_W = 4;
    localparam int unsigned DIGITS = BCD_W / 4;

    localparam logic [LVL_W-1:0]  LAST_LVL   = LVL_W'(NUM_LEVELS - 1);
    localparam logic [CNT_W-1:0]  INIT_LAST  = CNT_W'(INIT_FRAMES - 1);
    localparam logic [CNT_W-1:0]  DEATH_LAST = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [FADE_W-1:0] FADE_MAX   = '1;
    localparam logic [BCD_W-1:0]  BCD_MAX    = BCD_W'(16'h9999);

    typedef enum logic [2:0] {
        IDLE, LOAD, PLAY, DYING, LVL_DONE, WON
    } state_t;

    state_t             state;
    state_t             state_n;
    logic               vs_q;
    logic               start_q;
    logic               tick;
    logic               press;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   frame_cnt_n;
    logic [LVL_W-1:0]   level;
    logic [LVL_W-1:0]   level_n;
    logic [BCD_W-1:0]   deaths_q;
    logic [BCD_W-1:0]   deaths_n;
    logic [FADE_W-1:0]  fade_q;
    logic [FADE_W-1:0]  fade_n;
    logic               init_q;
    logic               freeze_q;
    logic               won_q;

    assign tick  = !vs_q && bus.vs;
    assign press = !start_q && bus.start;

    // Decimal increment of a 4-digit BCD word, sticking at 9999.
    function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] d);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = d;
        carry = 1'b1;
        if (d != BCD_MAX) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (carry) begin
                    if (d[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = d[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, WON: if (press) state_n = LOAD;
            LOAD:      if (tick && frame_cnt == INIT_LAST) state_n = PLAY;
            PLAY: begin
                // Reaching the goal outranks a same-cycle collision.
                if (bus.new_level)  state_n = LVL_DONE;
                else if (bus.dead)  state_n = DYING;
            end
            DYING:     if (tick && frame_cnt == DEATH_LAST) state_n = LOAD;
            LVL_DONE:  if (tick && frame_cnt == DEATH_LAST) state_n = (level == LAST_LVL) ? WON : LOAD;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_n = frame_cnt + CNT_W'(tick);
        level_n     = level;
        deaths_n    = deaths_q;
        fade_n      = fade_q;
        if (state_n != state) frame_cnt_n = '0;
        if ((state == IDLE || state == WON) && state_n == LOAD) begin
            level_n  = '0;
            deaths_n = '0;
        end
        if (state == LVL_DONE && state_n == LOAD) level_n = level + LVL_W'(1);
        if (state == PLAY && state_n == DYING) deaths_n = bcd_inc_sat(deaths_q);
        if ((state == DYING || state == LVL_DONE) && tick && fade_q != FADE_MAX)
            fade_n = fade_q + FADE_W'(1);
        // Fade is held through WON and dropped everywhere the screen should be bright.
        if (state_n == IDLE || state_n == LOAD || state_n == PLAY) fade_n = '0;
    end

    // vs_q/start_q reset high so the first cycle out of reset can't see an edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            vs_q      <= 1'b1;
            start_q   <= 1'b1;
            frame_cnt <= '0;
            level     <= '0;
            deaths_q  <= '0;
            fade_q    <= '0;
            init_q    <= 1'b0;
            freeze_q  <= 1'b1;
            won_q     <= 1'b0;
        end else begin
            vs_q      <= bus.vs;
            start_q   <= bus.start;
            frame_cnt <= frame_cnt_n;
            level     <= level_n;
            deaths_q  <= deaths_n;
            fade_q    <= fade_n;
            init_q    <= (state_n == LOAD);
            freeze_q  <= (state_n != PLAY);
            won_q     <= (state_n == WON);
        end
    end

    assign bus.initialize_level = init_q;
    assign bus.level_idx        = level;
    assign bus.deaths_bcd       = deaths_q;
    assign bus.freeze           = freeze_q;
    assign bus.fade             = fade_q;
    assign bus.game_won         = won_q;

endmodule

// File: tb/tb_game_flow_controller.sv
// Bench for game_flow_controller: random vs pacing and player events against a phase/tick-count model.
module tb_game_flow_controller;
    localparam int unsigned NL    = 6;
    localparam int unsigned INIT  = 2;
    localparam int unsigned DEATH = 30;
    localparam logic [26:0] RST_VEC = {1'b0, 4'd0, 16'h0000, 1'b1, 4'd0, 1'b0};

    typedef enum int {P_IDLE, P_LOAD, P_PLAY, P_DYING, P_DONE, P_WON} phase_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    game_flow_controller_if bus();

    game_flow_controller #(
        .NUM_LEVELS  (NL),
        .INIT_FRAMES (INIT),
        .DEATH_FRAMES(DEATH)
    ) dut (
        .CLK  (clk),
        .RESET(reset),
        .bus  (bus)
    );

    int          vecs = 0;
    int          errs = 0;
    phase_t      m_phase;
    int          m_ticks, m_level, m_deaths, m_won_fade;
    int          tick_cnt = 0;
    bit          m_vs_prev, m_start_prev, m_tick, m_press;
    bit          force_on = 1'b0;
    int          force_dec = 0;
    logic [15:0] force_val;

    // Free-running vertical sync with random low/high widths.
    initial begin
        bus.vs = 1'b1;
        forever begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.vs = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            bus.vs = 1'b1;
        end
    end

    // Reference model: game phase, ticks spent in the phase, integer death count.
    initial begin
        phase_t nxt;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase = P_IDLE; m_ticks = 0; m_level = 0; m_deaths = 0; m_won_fade = 0;
                m_vs_prev = 1'b1; m_start_prev = 1'b1;
            end else begin
                m_tick  = !m_vs_prev && bus.vs;
                m_press = !m_start_prev && bus.start;
                m_vs_prev = bus.vs;
                m_start_prev = bus.start;
                if (m_tick) begin m_ticks++; tick_cnt++; end
                if (force_on) m_deaths = force_dec;
                nxt = m_phase;
                case (m_phase)
                    P_IDLE, P_WON: if (m_press) begin nxt = P_LOAD; m_level = 0; m_deaths = 0; end
                    P_LOAD:  if (m_ticks == INIT) nxt = P_PLAY;
                    P_PLAY: begin
                        if (bus.new_level) nxt = P_DONE;
                        else if (bus.dead) begin nxt = P_DYING; m_deaths++; end
                    end
                    P_DYING: if (m_ticks == DEATH) nxt = P_LOAD;
                    P_DONE: begin
                        if (m_ticks == DEATH) begin
                            if (m_level == NL - 1) begin
                                nxt = P_WON;
                                m_won_fade = (m_ticks > 15) ? 15 : m_ticks;
                            end else begin
                                m_level++;
                                nxt = P_LOAD;
                            end
                        end
                    end
                    default: nxt = P_IDLE;
                endcase
                if (nxt != m_phase) m_ticks = 0;
                m_phase = nxt;
            end
        end
    end

    function automatic logic [26:0] exp_vec();
        int f;
        int d;
        f = 0;
        if (m_phase == P_DYING || m_phase == P_DONE) f = (m_ticks > 15) ? 15 : m_ticks;
        else if (m_phase == P_WON) f = m_won_fade;
        d = (m_deaths > 9999) ? 9999 : m_deaths;
        return {m_phase == P_LOAD, 4'(m_level), 4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10),
                4'(d % 10), m_phase != P_PLAY, 4'(f), m_phase == P_WON};
    endfunction

    function automatic logic [26:0] dut_vec();
        return {bus.initialize_level, bus.level_idx, bus.deaths_bcd, bus.freeze, bus.fade, bus.game_won};
    endfunction

    task automatic wait_phase(input phase_t p, input int budget, output bit ok);
        ok = (m_phase == p);
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            ok = (m_phase == p);
        end
    endtask

    task automatic test_reset();
        int t0;
        bit ok;
        reset = 1'b1; bus.start = 1'b1; bus.dead = 1'b0; bus.new_level = 1'b0;
        repeat (3) @(negedge clk);
        vecs++;
        if (dut_vec() !== RST_VEC) begin errs++; $display("FAIL reset_vals: got %h want %h", dut_vec(), RST_VEC); end
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== RST_VEC) begin errs++; $display("FAIL start_held: got %h want %h", dut_vec(), RST_VEC); end
        end
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        vecs++;
        if (bus.initialize_level !== 1'b1) begin errs++; $display("FAIL load_on_press: got %b want 1", bus.initialize_level); end
        t0 = tick_cnt;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            vecs++;
            if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL load_seq: got %h want %h", dut_vec(), exp_vec()); end
            bus.start = 1'($urandom_range(0, 1));
            @(negedge clk);
            ok = (bus.initialize_level === 1'b0);
        end
        bus.start = 1'b0;
        vecs++;
        if (tick_cnt - t0 != INIT) begin errs++; $display("FAIL init_ticks: got %0d want %0d", tick_cnt - t0, INIT); end
        vecs++;
        if (bus.freeze !== 1'b0) begin errs++; $display("FAIL play_freeze: got %b want 0", bus.freeze); end
    endtask

    task automatic test_death();
        repeat ($urandom_range(1, 20)) begin
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL play_hold: got %h want %h", dut_vec(), exp_vec()); end
        end
        bus.dead = 1'b1;
        @(negedge clk);
        bus.dead = 1'b0;
        vecs++;
        if (bus.deaths_bcd !== 16'h0001) begin errs++; $display("FAIL death_inc: got %h want 0001", bus.deaths_bcd); end
        for (int i = 0; i < 1000 && m_phase == P_DYING; i++) begin
            bus.dead = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL dying_seq: got %h want %h", dut_vec(), exp_vec()); end
            if (m_phase == P_DYING && m_ticks == 15) begin
                vecs++;
                if (bus.fade !== 4'd15) begin errs++; $display("FAIL fade_tick15: got %0d want 15", bus.fade); end
            end
        end
        bus.dead = 1'b0;
        vecs++;
        if ({bus.initialize_level, bus.level_idx, bus.deaths_bcd} !== {1'b1, 4'd0, 16'h0001}) begin
            errs++;
            $display("FAIL death_reload: got %h want %h", {bus.initialize_level, bus.level_idx, bus.deaths_bcd},
                     {1'b1, 4'd0, 16'h0001});
        end
    endtask

    task automatic test_bcd_carry();
        for (int k = 0; k < 3; k++) begin
            logic [15:0] want;
            bit ok;
            case (k)
                0:       begin force_val = 16'h0009; force_dec = 9;    want = 16'h0010; end
                1:       begin force_val = 16'h0099; force_dec = 99;   want = 16'h0100; end
                default: begin force_val = 16'h9999; force_dec = 9999; want = 16'h9999; end
            endcase
            wait_phase(P_PLAY, 1000, ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL bcd_wait_play: got timeout want PLAY"); end
            force dut.deaths_q = force_val;
            force_on = 1'b1;
            @(negedge clk);
            release dut.deaths_q;
            force_on = 1'b0;
            bus.dead = 1'b1;
            @(negedge clk);
            bus.dead = 1'b0;
            vecs++;
            if (bus.deaths_bcd !== want) begin errs++; $display("FAIL bcd_carry: got %h want %h", bus.deaths_bcd, want); end
            vecs++;
            if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL bcd_model: got %h want %h", dut_vec(), exp_vec()); end
        end
    endtask

    task automatic test_priority();
        bit ok;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_phase(P_PLAY, 500, ok);
        vecs++;
        if (!ok) begin errs++; $display("FAIL prio_wait_play: got timeout want PLAY"); end
        repeat ($urandom_range(0, 5)) @(negedge clk);
        bus.dead = 1'b1;
        bus.new_level = 1'b1;
        @(negedge clk);
        bus.dead = 1'b0;
        bus.new_level = 1'b0;
        vecs++;
        if ({bus.deaths_bcd, bus.freeze, bus.level_idx} !== {16'h0000, 1'b1, 4'd0}) begin
            errs++;
            $display("FAIL prio_win: got %h want %h", {bus.deaths_bcd, bus.freeze, bus.level_idx}, {16'h0000, 1'b1, 4'd0});
        end
        for (int i = 0; i < 1000 && m_phase == P_DONE; i++) begin
            bus.dead = ($urandom_range(0, 3) == 0);
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL lvl_done_seq: got %h want %h", dut_vec(), exp_vec()); end
        end
        bus.dead = 1'b0;
        vecs++;
        if ({bus.initialize_level, bus.level_idx, bus.deaths_bcd} !== {1'b1, 4'd1, 16'h0000}) begin
            errs++;
            $display("FAIL prio_next: got %h want %h", {bus.initialize_level, bus.level_idx, bus.deaths_bcd},
                     {1'b1, 4'd1, 16'h0000});
        end
    endtask

    task automatic test_all_levels();
        bit ok;
        for (int lvl = 1; lvl < NL; lvl++) begin
            wait_phase(P_PLAY, 1000, ok);
            vecs++;
            if (!ok) begin errs++; $display("FAIL lvl_wait_play: got timeout want PLAY level %0d", lvl); end
            if (lvl == 3) begin
                bus.dead = 1'b1;
                @(negedge clk);
                bus.dead = 1'b0;
                wait_phase(P_PLAY, 1000, ok);
            end
            repeat ($urandom_range(0, 5)) @(negedge clk);
            bus.new_level = 1'b1;
            @(negedge clk);
            bus.new_level = 1'b0;
            for (int i = 0; i < 1000 && m_phase == P_DONE; i++) begin
                bus.dead = ($urandom_range(0, 3) == 0);
                @(negedge clk);
                vecs++;
                if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL levels_seq: got %h want %h", dut_vec(), exp_vec()); end
            end
            bus.dead = 1'b0;
        end
        vecs++;
        if ({bus.game_won, bus.level_idx, bus.freeze, bus.fade} !== {1'b1, 4'(NL - 1), 1'b1, 4'd15}) begin
            errs++;
            $display("FAIL won_state: got %h want %h", {bus.game_won, bus.level_idx, bus.freeze, bus.fade},
                     {1'b1, 4'(NL - 1), 1'b1, 4'd15});
        end
        repeat (20) begin
            bus.dead = 1'($urandom_range(0, 1));
            bus.new_level = 1'($urandom_range(0, 1));
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL won_hold: got %h want %h", dut_vec(), exp_vec()); end
        end
        bus.dead = 1'b0;
        bus.new_level = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        vecs++;
        if ({bus.level_idx, bus.deaths_bcd, bus.initialize_level, bus.game_won} !== {4'd0, 16'h0000, 1'b1, 1'b0}) begin
            errs++;
            $display("FAIL restart: got %h want %h", {bus.level_idx, bus.deaths_bcd, bus.initialize_level, bus.game_won},
                     {4'd0, 16'h0000, 1'b1, 1'b0});
        end
    endtask

    task automatic test_reset_mid_dying();
        bit ok;
        wait_phase(P_PLAY, 1000, ok);
        bus.dead = 1'b1;
        @(negedge clk);
        bus.dead = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = (m_phase == P_DYING && m_ticks == 7);
        end
        vecs++;
        if (bus.fade !== 4'd7) begin errs++; $display("FAIL fade_before_reset: got %0d want 7", bus.fade); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vecs++;
        if (dut_vec() !== RST_VEC) begin errs++; $display("FAIL reset_mid_dying: got %h want %h", dut_vec(), RST_VEC); end
    endtask

    task automatic test_random();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            bus.dead      = ($urandom_range(0, 7) == 0);
            bus.new_level = ($urandom_range(0, 15) == 0);
            bus.start     = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            vecs++;
            if (dut_vec() !== exp_vec()) begin errs++; $display("FAIL random: got %h want %h", dut_vec(), exp_vec()); end
        end
        bus.dead = 1'b0;
        bus.new_level = 1'b0;
        bus.start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b1;
        bus.dead = 1'b0;
        bus.new_level = 1'b0;
        force_val = 16'h0000;
        test_reset();
        test_death();
        test_bcd_carry();
        test_priority();
        test_all_levels();
        test_reset_mid_dying();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
